// File: rtl/xor_cipher_ctrl.sv
// xor_cipher_ctrl
//   Byte-serial front end and sequencer for the XOR cipher datapath.
//   Assembles key and message words from host bytes (first byte lands in the
//   MSBs), enables the datapath, captures the ciphertext on done and streams
//   it back MSB byte first over a valid/ready handshake. One transaction per
//   reset; the datapath done flag is sticky.
//
// Ports
//   iClk, iRst                 clock, async active-low reset
//   iByte_valid/iByte/iSel_key host byte strobe, data, key(1)/message(0) select
//   oByte_ready                selected buffer can take a byte (LOAD only)
//   oKey, oMessage             assembled words to datapath
//   oKey_assemble_counter      key bits loaded
//   oMessage_counter           message bits loaded
//   oCan_encrypt               datapath enable
//   iEncrypt_done, iCiphertext datapath result
//   oOut_valid/oOut_byte       ciphertext byte stream, iOut_ready from sink
//   oBusy, oDone               status
module xor_cipher_ctrl #(
    parameter int MSG_SIZE = 512
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iByte_valid,
    input  logic [7:0]          iByte,
    input  logic                iSel_key,
    output logic                oByte_ready,
    output logic [MSG_SIZE-1:0] oKey,
    output logic [MSG_SIZE-1:0] oMessage,
    output logic [9:0]          oKey_assemble_counter,
    output logic [9:0]          oMessage_counter,
    output logic                oCan_encrypt,
    input  logic                iEncrypt_done,
    input  logic [MSG_SIZE-1:0] iCiphertext,
    output logic                oOut_valid,
    output logic [7:0]          oOut_byte,
    input  logic                iOut_ready,
    output logic                oBusy,
    output logic                oDone
);

    localparam int NBYTES = MSG_SIZE / 8;
    localparam int IDXW   = $clog2(NBYTES + 1);

    typedef enum logic [2:0] {
        LOAD,
        ENCRYPT,
        WAIT_DONE,
        STREAM,
        DONE
    } state_t;

    state_t              state, nextState;
    logic [MSG_SIZE-1:0] shreg;
    logic [IDXW-1:0]     idx;

    logic keyFull, msgFull, accept, outHs, lastHs;

    assign keyFull   = (oKey_assemble_counter == 10'(MSG_SIZE));
    assign msgFull   = (oMessage_counter == 10'(MSG_SIZE));
    assign accept    = iByte_valid && oByte_ready;
    // oOut_valid is only ever high in STREAM, so it qualifies the handshake
    assign outHs     = oOut_valid && iOut_ready;
    assign lastHs    = outHs && (idx == IDXW'(NBYTES - 1));
    assign oOut_byte = shreg[MSG_SIZE-1 -: 8];

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) state <= LOAD;
        else       state <= nextState;
    end

    always_comb begin
        nextState   = state;
        oByte_ready = 1'b0;
        case (state)
            LOAD: begin
                oByte_ready = iSel_key ? !keyFull : !msgFull;
                // registered counters: leaves LOAD the cycle after the final accept
                if (keyFull && msgFull) nextState = ENCRYPT;
            end
            ENCRYPT:   nextState = WAIT_DONE;
            WAIT_DONE: if (iEncrypt_done) nextState = STREAM;
            STREAM:    if (lastHs) nextState = DONE;
            DONE:      nextState = DONE;
            default:   nextState = LOAD;
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oKey                  <= '0;
            oMessage              <= '0;
            oKey_assemble_counter <= '0;
            oMessage_counter      <= '0;
            shreg                 <= '0;
            idx                   <= '0;
            oCan_encrypt          <= 1'b0;
            oOut_valid            <= 1'b0;
            oBusy                 <= 1'b0;
            oDone                 <= 1'b0;
        end else begin
            if (accept) begin
                if (iSel_key) begin
                    oKey                  <= (oKey << 8) | MSG_SIZE'(iByte);
                    oKey_assemble_counter <= oKey_assemble_counter + 10'd8;
                end else begin
                    oMessage         <= (oMessage << 8) | MSG_SIZE'(iByte);
                    oMessage_counter <= oMessage_counter + 10'd8;
                end
            end

            if (state == WAIT_DONE && iEncrypt_done) begin
                shreg <= iCiphertext;
                idx   <= '0;
            end else if (state == STREAM && outHs) begin
                shreg <= shreg << 8;
                idx   <= idx + IDXW'(1);
            end

            oCan_encrypt <= (nextState == ENCRYPT) || (nextState == WAIT_DONE);
            oOut_valid   <= (nextState == STREAM);
            oBusy        <= (nextState != LOAD) && (nextState != DONE);
            oDone        <= (nextState == DONE);
        end
    end

endmodule

// File: tb/tb_xor_cipher_ctrl.sv
module tb_xor_cipher_ctrl;

    logic iClk, iRst;
    int   nChecks = 0;
    int   nFail   = 0;

    // DUT A: 32-bit block
    logic        aValid, aSel, aReady, aCe, aDp, aOv, aOr, aBusy, aDone;
    logic [7:0]  aByte, aOb;
    logic [31:0] aKey, aMsg, aCt;
    logic [9:0]  aKc, aMc;

    // DUT B: default 512-bit block
    logic         bValid, bSel, bReady, bCe, bDp, bOv, bOr, bBusy, bDone;
    logic [7:0]   bByte, bOb;
    logic [511:0] bKey, bMsg, bCt;
    logic [9:0]   bKc, bMc;

    xor_cipher_ctrl #(.MSG_SIZE(32)) dutA (
        .iClk(iClk), .iRst(iRst), .iByte_valid(aValid), .iByte(aByte), .iSel_key(aSel),
        .oByte_ready(aReady), .oKey(aKey), .oMessage(aMsg),
        .oKey_assemble_counter(aKc), .oMessage_counter(aMc), .oCan_encrypt(aCe),
        .iEncrypt_done(aDp), .iCiphertext(aCt), .oOut_valid(aOv), .oOut_byte(aOb),
        .iOut_ready(aOr), .oBusy(aBusy), .oDone(aDone));

    xor_cipher_ctrl dutB (
        .iClk(iClk), .iRst(iRst), .iByte_valid(bValid), .iByte(bByte), .iSel_key(bSel),
        .oByte_ready(bReady), .oKey(bKey), .oMessage(bMsg),
        .oKey_assemble_counter(bKc), .oMessage_counter(bMc), .oCan_encrypt(bCe),
        .iEncrypt_done(bDp), .iCiphertext(bCt), .oOut_valid(bOv), .oOut_byte(bOb),
        .iOut_ready(bOr), .oBusy(bBusy), .oDone(bDone));

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Ideal XOR datapath: sticky done one cycle after enable
    always @(posedge iClk or negedge iRst) begin
        if (!iRst) begin aDp <= 1'b0; bDp <= 1'b0; end
        else begin
            if (aCe) aDp <= 1'b1;
            if (bCe) bDp <= 1'b1;
        end
    end
    assign aCt = aKey ^ aMsg;
    assign bCt = bKey ^ bMsg;

    // All stimulus changes and all sampling happen at the falling edge.
    task automatic doReset();
        iRst = 1'b0;
        @(negedge iClk);
        iRst = 1'b1;
    endtask

    task automatic sendA(input logic sel, input logic [7:0] b);
        aSel = sel; aByte = b; aValid = 1'b1;
        @(negedge iClk);
        aValid = 1'b0;
    endtask

    task automatic sendB(input logic sel, input logic [7:0] b);
        bSel = sel; bByte = b; bValid = 1'b1;
        @(negedge iClk);
        bValid = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        nChecks++; if (aKey !== 32'h0)  begin nFail++; $display("FAIL reset_key got %h want 0", aKey); end
        nChecks++; if (aMsg !== 32'h0)  begin nFail++; $display("FAIL reset_msg got %h want 0", aMsg); end
        nChecks++; if (aKc !== 10'd0)   begin nFail++; $display("FAIL reset_kc got %0d want 0", aKc); end
        nChecks++; if (aMc !== 10'd0)   begin nFail++; $display("FAIL reset_mc got %0d want 0", aMc); end
        nChecks++; if (aCe !== 1'b0)    begin nFail++; $display("FAIL reset_ce got %b want 0", aCe); end
        nChecks++; if (aOv !== 1'b0)    begin nFail++; $display("FAIL reset_ov got %b want 0", aOv); end
        nChecks++; if (aOb !== 8'h00)   begin nFail++; $display("FAIL reset_ob got %h want 00", aOb); end
        nChecks++; if (aBusy !== 1'b0)  begin nFail++; $display("FAIL reset_busy got %b want 0", aBusy); end
        nChecks++; if (aDone !== 1'b0)  begin nFail++; $display("FAIL reset_done got %b want 0", aDone); end
        nChecks++; if (aReady !== 1'b1) begin nFail++; $display("FAIL reset_ready got %b want 1", aReady); end
    endtask

    task automatic test_reset_mid_load();
        doReset();
        sendA(1'b1, 8'h11); sendA(1'b1, 8'h22); sendA(1'b1, 8'h33);
        nChecks++; if (aKc !== 10'd24)     begin nFail++; $display("FAIL midload_kc got %0d want 24", aKc); end
        nChecks++; if (aKey !== 32'h112233) begin nFail++; $display("FAIL midload_key got %h want 00112233", aKey); end
        #2 iRst = 1'b0;
        #1;
        nChecks++; if (aKc !== 10'd0) begin nFail++; $display("FAIL async_reset_kc got %0d want 0", aKc); end
        @(negedge iClk);
        iRst = 1'b1;
        nChecks++; if (aKey !== 32'h0)  begin nFail++; $display("FAIL midreset_key got %h want 0", aKey); end
        nChecks++; if (aReady !== 1'b1) begin nFail++; $display("FAIL midreset_ready got %b want 1", aReady); end
        nChecks++; if (aBusy !== 1'b0)  begin nFail++; $display("FAIL midreset_busy got %b want 0", aBusy); end
    endtask

    // Streams DUT A's ciphertext with a 4-cycle repeating ready pattern
    // (bit i = ready on cycle i) and checks order, stability and count.
    task automatic streamA(input logic [3:0] pat, input string tag);
        logic [7:0] expB [4];
        logic [7:0] prevByte;
        logic       prevHeld;
        int         hs;
        expB[0] = 8'hF1; expB[1] = 8'hE3; expB[2] = 8'hD1; expB[3] = 8'hC7;
        hs = 0; prevHeld = 1'b0; prevByte = 8'h00;
        for (int cyc = 0; cyc < 100 && !aDone; cyc++) begin
            if (prevHeld) begin
                nChecks++;
                if (aOv !== 1'b1 || aOb !== prevByte) begin
                    nFail++; $display("FAIL %s_hold got v=%b %h want v=1 %h", tag, aOv, aOb, prevByte);
                end
            end
            aOr = pat[cyc % 4];
            if (aOv && aOr) begin
                nChecks++;
                if (hs >= 4 || aOb !== expB[hs % 4]) begin
                    nFail++; $display("FAIL %s_byte%0d got %h want %h", tag, hs, aOb, expB[hs % 4]);
                end
                hs++;
            end
            prevHeld = aOv && !aOr;
            prevByte = aOb;
            @(negedge iClk);
        end
        aOr = 1'b0;
        nChecks++; if (hs != 4)        begin nFail++; $display("FAIL %s_count got %0d want 4", tag, hs); end
        nChecks++; if (aDone !== 1'b1) begin nFail++; $display("FAIL %s_done got %b want 1", tag, aDone); end
        nChecks++; if (aOv !== 1'b0)   begin nFail++; $display("FAIL %s_ov_after got %b want 0", tag, aOv); end
        nChecks++; if (aBusy !== 1'b0) begin nFail++; $display("FAIL %s_busy_after got %b want 0", tag, aBusy); end
    endtask

    task automatic test_overfill_full_flow();
        doReset();
        sendA(1'b1, 8'h01); sendA(1'b1, 8'h02); sendA(1'b1, 8'h03); sendA(1'b1, 8'h04);
        aSel = 1'b1; aByte = 8'h99; aValid = 1'b1;
        #1;
        nChecks++; if (aReady !== 1'b0) begin nFail++; $display("FAIL overfill_ready got %b want 0", aReady); end
        @(negedge iClk);
        nChecks++; if (aKey !== 32'h01020304) begin nFail++; $display("FAIL overfill_key got %h want 01020304", aKey); end
        nChecks++; if (aKc !== 10'd32)        begin nFail++; $display("FAIL overfill_kc got %0d want 32", aKc); end
        aSel = 1'b0; aByte = 8'hF0;
        #1;
        nChecks++; if (aReady !== 1'b1) begin nFail++; $display("FAIL overfill_msg_ready got %b want 1", aReady); end
        @(negedge iClk);
        aValid = 1'b0;
        nChecks++; if (aMc !== 10'd8) begin nFail++; $display("FAIL overfill_mc got %0d want 8", aMc); end
        sendA(1'b0, 8'hE1); sendA(1'b0, 8'hD2); sendA(1'b0, 8'hC3);
        // one half-cycle after the final accept edge N
        nChecks++; if (aMsg !== 32'hF0E1D2C3) begin nFail++; $display("FAIL flow_msg got %h want F0E1D2C3", aMsg); end
        nChecks++; if (aCe !== 1'b0)          begin nFail++; $display("FAIL flow_ce_N got %b want 0", aCe); end
        @(negedge iClk);
        nChecks++; if (aCe !== 1'b1)   begin nFail++; $display("FAIL flow_ce_N1 got %b want 1", aCe); end
        nChecks++; if (aBusy !== 1'b1) begin nFail++; $display("FAIL flow_busy got %b want 1", aBusy); end
        @(negedge iClk);
        nChecks++; if (aCe !== 1'b1) begin nFail++; $display("FAIL flow_ce_N2 got %b want 1", aCe); end
        nChecks++; if (aOv !== 1'b0) begin nFail++; $display("FAIL flow_ov_N2 got %b want 0", aOv); end
        @(negedge iClk);
        nChecks++; if (aOv !== 1'b1)  begin nFail++; $display("FAIL flow_ov_N3 got %b want 1", aOv); end
        nChecks++; if (aCe !== 1'b0)  begin nFail++; $display("FAIL flow_ce_N3 got %b want 0", aCe); end
        nChecks++; if (aOb !== 8'hF1) begin nFail++; $display("FAIL flow_first got %h want F1", aOb); end
        streamA(4'b1111, "flow");
    endtask

    task automatic test_interleaved_backpressure();
        logic [7:0] m [4];
        m[0] = 8'hF0; m[1] = 8'hE1; m[2] = 8'hD2; m[3] = 8'hC3;
        doReset();
        for (int i = 0; i < 4; i++) begin
            sendA(1'b1, 8'(i + 1));
            sendA(1'b0, m[i]);
        end
        nChecks++; if (aKey !== 32'h01020304) begin nFail++; $display("FAIL inter_key got %h want 01020304", aKey); end
        nChecks++; if (aMsg !== 32'hF0E1D2C3) begin nFail++; $display("FAIL inter_msg got %h want F0E1D2C3", aMsg); end
        nChecks++; if (aKc !== 10'd32 || aMc !== 10'd32) begin nFail++; $display("FAIL inter_cnt got %0d/%0d want 32/32", aKc, aMc); end
        nChecks++; if (aCe !== 1'b0) begin nFail++; $display("FAIL inter_ce_N got %b want 0", aCe); end
        @(negedge iClk);
        nChecks++; if (aCe !== 1'b1) begin nFail++; $display("FAIL inter_ce_N1 got %b want 1", aCe); end
        streamA(4'b1001, "bp");
    endtask

    task automatic test_default_size();
        logic [511:0] expKey, expMsg;
        int hs;
        expKey = {64{8'hAA}};
        expMsg = {64{8'h55}};
        bOr = 1'b0;
        doReset();
        for (int i = 0; i < 64; i++) sendB(1'b1, 8'hAA);
        for (int i = 0; i < 64; i++) sendB(1'b0, 8'h55);
        nChecks++; if (bKey !== expKey) begin nFail++; $display("FAIL big_key got %h want %h", bKey[31:0], expKey[31:0]); end
        nChecks++; if (bMsg !== expMsg) begin nFail++; $display("FAIL big_msg got %h want %h", bMsg[31:0], expMsg[31:0]); end
        nChecks++; if (bKc !== 10'd512 || bMc !== 10'd512) begin nFail++; $display("FAIL big_cnt got %0d/%0d want 512/512", bKc, bMc); end
        hs = 0;
        bOr = 1'b1;
        for (int cyc = 0; cyc < 200 && !bDone; cyc++) begin
            if (bOv) begin
                nChecks++;
                if (bOb !== 8'hFF) begin nFail++; $display("FAIL big_byte%0d got %h want FF", hs, bOb); end
                hs++;
            end
            @(negedge iClk);
        end
        bOr = 1'b0;
        nChecks++; if (hs != 64)       begin nFail++; $display("FAIL big_count got %0d want 64", hs); end
        nChecks++; if (bDone !== 1'b1) begin nFail++; $display("FAIL big_done got %b want 1", bDone); end
        nChecks++; if (bOv !== 1'b0)   begin nFail++; $display("FAIL big_ov_after got %b want 0", bOv); end
        bSel = 1'b1; bByte = 8'h12; bValid = 1'b1;
        #1;
        nChecks++; if (bReady !== 1'b0) begin nFail++; $display("FAIL big_key_ready_done got %b want 0", bReady); end
        @(negedge iClk);
        bSel = 1'b0;
        #1;
        nChecks++; if (bReady !== 1'b0) begin nFail++; $display("FAIL big_msg_ready_done got %b want 0", bReady); end
        @(negedge iClk);
        bValid = 1'b0;
        nChecks++; if (bKey !== expKey || bMsg !== expMsg) begin nFail++; $display("FAIL big_hold got %h/%h", bKey[31:0], bMsg[31:0]); end
        nChecks++; if (bKc !== 10'd512 || bMc !== 10'd512) begin nFail++; $display("FAIL big_cnt_hold got %0d/%0d want 512/512", bKc, bMc); end
        nChecks++; if (bDone !== 1'b1) begin nFail++; $display("FAIL big_done_hold got %b want 1", bDone); end
    endtask

    initial begin
        iRst = 1'b0;
        aValid = 1'b0; aSel = 1'b0; aByte = 8'h00; aOr = 1'b0;
        bValid = 1'b0; bSel = 1'b0; bByte = 8'h00; bOr = 1'b0;
        @(negedge iClk);
        test_reset();
        test_reset_mid_load();
        test_overfill_full_flow();
        test_interleaved_backpressure();
        test_default_size();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
